cpu_mem_tester: RTL and testbench

Synthesizable CPU-side traffic generator and checker that drives the TG68-style cpu port of sdram_ctrl (cpuAddr/cpuState/cpuL/cpuU/cpuWR in, cpuRD/clkena out).
It writes a pseudo-random word pattern over an address window, then reads the window back and compares.
It replaces the free-running fake CPU in the cpu/cache/sdram benches.
It is also usable on hardware as a power-on memory self-test ahead of the real CPU.

---
 rtl/cpu_mem_tester.sv | 235 +++++++++++++++++++++++
 tb/tb_cpu_mem_tester.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_tester.sv
// CPU-side memory traffic generator/checker for the sdram_ctrl TG68-style cpu port.
// Writes an LFSR word pattern over an address window, then reads it back and compares.
// Each bus access is held stable until a clkena edge completes it; idle gaps are counted in clkena strobes.
module cpu_mem_tester #(
   parameter logic [15:0] SEED     = 16'hACE1,
   parameter int          IDLE_GAP = 0
) (
   input  logic        clk_114,
   input  logic        reset_n,
   input  logic        start,
   input  logic [23:0] base_addr,
   input  logic [15:0] length,
   output logic [23:0] cpuAddr,
   output logic [1:0]  cpuState,
   output logic        cpuL,
   output logic        cpuU,
   output logic        cpuLongWord,
   output logic [15:0] cpuWR,
   input  logic [15:0] cpuRD,
   input  logic        clkena,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [23:0] err_addr,
   output logic [15:0] err_data,
   output logic [15:0] err_exp
);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_WGAP, S_RD, S_RGAP, S_FIN} state_t;

   localparam bit         HAS_GAP  = (IDLE_GAP != 0);
   localparam logic [3:0] GAP_LAST = IDLE_GAP[3:0] - 4'd1;

   localparam logic [1:0] BUS_IDLE = 2'b01;
   localparam logic [1:0] BUS_WR   = 2'b11;
   localparam logic [1:0] BUS_RD   = 2'b10;

   state_t      state_q, state_d;
   logic [23:0] addr_q, addr_d;
   logic [23:0] base_q, base_d;
   logic [15:0] len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [15:0] wr_q, wr_d;
   logic [3:0]  gap_q, gap_d;
   logic        pass_q, pass_d;
   logic [15:0] err_count_q, err_count_d;
   logic [23:0] err_addr_q, err_addr_d;
   logic [15:0] err_data_q, err_data_d;
   logic [15:0] err_exp_q, err_exp_d;

   // Fibonacci LFSR, taps 16,14,13,11, shifting left with feedback into bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   logic last_word;
   assign last_word = (cnt_q == (len_q - 16'd1));

   // Next-state and datapath update; every register holds unless a clkena edge completes something.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      base_d      = base_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      lfsr_d      = lfsr_q;
      wr_d        = wr_q;
      gap_d       = gap_q;
      pass_d      = pass_q;
      err_count_d = err_count_q;
      err_addr_d  = err_addr_q;
      err_data_d  = err_data_q;
      err_exp_d   = err_exp_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d      = base_addr;
               len_d       = length;
               pass_d      = 1'b0;
               err_count_d = '0;
               err_addr_d  = '0;
               err_data_d  = '0;
               err_exp_d   = '0;
               cnt_d       = '0;
               addr_d      = base_addr;
               lfsr_d      = SEED;
               wr_d        = SEED;
               if (length == 16'd0) begin
                  pass_d  = 1'b1;
                  state_d = S_FIN;
               end else begin
                  state_d = S_WR;
               end
            end
         end

         S_WR: begin
            if (clkena) begin
               gap_d = '0;
               if (last_word) begin
                  // Rewind for the read-back pass; the gap (if any) still precedes the first read.
                  cnt_d   = '0;
                  addr_d  = base_q;
                  lfsr_d  = SEED;
                  state_d = HAS_GAP ? S_WGAP : S_RD;
               end else begin
                  cnt_d   = cnt_q + 16'd1;
                  addr_d  = addr_q + 24'd1;
                  lfsr_d  = lfsr_step(lfsr_q);
                  wr_d    = lfsr_step(lfsr_q);
                  state_d = HAS_GAP ? S_WGAP : S_WR;
               end
            end
         end

         S_WGAP: begin
            if (clkena) begin
               if (gap_q == GAP_LAST) begin
                  // cnt is only zero here after the final write was completed.
                  state_d = (cnt_q == 16'd0) ? S_RD : S_WR;
               end else begin
                  gap_d = gap_q + 4'd1;
               end
            end
         end

         S_RD: begin
            if (clkena) begin
               gap_d = '0;
               if (cpuRD != lfsr_q) begin
                  if (err_count_q == 16'd0) begin
                     err_addr_d = addr_q;
                     err_data_d = cpuRD;
                     err_exp_d  = lfsr_q;
                  end
                  if (err_count_q != 16'hFFFF) begin
                     err_count_d = err_count_q + 16'd1;
                  end
               end
               cnt_d  = cnt_q + 16'd1;
               addr_d = addr_q + 24'd1;
               lfsr_d = lfsr_step(lfsr_q);
               if (last_word) begin
                  pass_d  = (err_count_d == 16'd0);
                  state_d = S_FIN;
               end else begin
                  state_d = HAS_GAP ? S_RGAP : S_RD;
               end
            end
         end

         S_RGAP: begin
            if (clkena) begin
               if (gap_q == GAP_LAST) begin
                  state_d = S_RD;
               end else begin
                  gap_d = gap_q + 4'd1;
               end
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any test in flight.
   always_ff @(posedge clk_114 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         base_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         lfsr_q      <= SEED;
         wr_q        <= '0;
         gap_q       <= '0;
         pass_q      <= 1'b0;
         err_count_q <= '0;
         err_addr_q  <= '0;
         err_data_q  <= '0;
         err_exp_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         base_q      <= base_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         lfsr_q      <= lfsr_d;
         wr_q        <= wr_d;
         gap_q       <= gap_d;
         pass_q      <= pass_d;
         err_count_q <= err_count_d;
         err_addr_q  <= err_addr_d;
         err_data_q  <= err_data_d;
         err_exp_q   <= err_exp_d;
      end
   end

   // Bus-cycle type and strobes decode straight from the state register, so they change only on edges.
   always_comb begin
      cpuState = BUS_IDLE;
      cpuL     = 1'b1;
      cpuU     = 1'b1;
      if (state_q == S_WR) begin
         cpuState = BUS_WR;
         cpuL     = 1'b0;
         cpuU     = 1'b0;
      end else if (state_q == S_RD) begin
         cpuState = BUS_RD;
         cpuL     = 1'b0;
         cpuU     = 1'b0;
      end
   end

   assign cpuAddr     = addr_q;
   assign cpuWR       = wr_q;
   assign cpuLongWord = 1'b0;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_FIN);
   assign pass        = pass_q;
   assign err_count   = err_count_q;
   assign err_addr    = err_addr_q;
   assign err_data    = err_data_q;
   assign err_exp     = err_exp_q;

endmodule

// File: tb/tb_cpu_mem_tester.sv
// Directed bench for cpu_mem_tester: ideal memory model, forced read error, wrap, idle gaps, reset abort.
// Two instances share the clock: dut0 with no idle gap, dut1 with IDLE_GAP=2.
// clkena for dut0 strobes every 4th cycle; dut1 sees clkena held high.
module tb_cpu_mem_tester;

   logic        clk_114 = 1'b0;
   logic        reset_n = 1'b0;
   always #5 clk_114 = ~clk_114;

   // dut0 signals
   logic        start0 = 1'b0;
   logic [23:0] base0  = '0;
   logic [15:0] len0   = '0;
   logic [23:0] cpuAddr0;
   logic [1:0]  cpuState0;
   logic        cpuL0, cpuU0, cpuLW0;
   logic [15:0] cpuWR0;
   logic [15:0] cpuRD0 = '0;
   logic        clkena0 = 1'b0;
   logic        busy0, done0, pass0;
   logic [15:0] err_count0, err_data0, err_exp0;
   logic [23:0] err_addr0;

   // dut1 signals
   logic        start1 = 1'b0;
   logic [23:0] base1  = '0;
   logic [15:0] len1   = '0;
   logic [23:0] cpuAddr1;
   logic [1:0]  cpuState1;
   logic        cpuL1, cpuU1, cpuLW1;
   logic [15:0] cpuWR1;
   logic [15:0] cpuRD1 = '0;
   logic        clkena1 = 1'b1;
   logic        busy1, done1, pass1;
   logic [15:0] err_count1, err_data1, err_exp1;
   logic [23:0] err_addr1;

   cpu_mem_tester dut0 (
      .clk_114(clk_114), .reset_n(reset_n), .start(start0), .base_addr(base0), .length(len0),
      .cpuAddr(cpuAddr0), .cpuState(cpuState0), .cpuL(cpuL0), .cpuU(cpuU0), .cpuLongWord(cpuLW0),
      .cpuWR(cpuWR0), .cpuRD(cpuRD0), .clkena(clkena0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err_count0), .err_addr(err_addr0), .err_data(err_data0), .err_exp(err_exp0)
   );

   cpu_mem_tester #(.IDLE_GAP(2)) dut1 (
      .clk_114(clk_114), .reset_n(reset_n), .start(start1), .base_addr(base1), .length(len1),
      .cpuAddr(cpuAddr1), .cpuState(cpuState1), .cpuL(cpuL1), .cpuU(cpuU1), .cpuLongWord(cpuLW1),
      .cpuWR(cpuWR1), .cpuRD(cpuRD1), .clkena(clkena1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err_count1), .err_addr(err_addr1), .err_data(err_data1), .err_exp(err_exp1)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // First LFSR words from 16'hACE1, worked by hand.
   logic [15:0] lfsr_tab [4] = '{16'hACE1, 16'h59C3, 16'hB387, 16'h670F};

   function automatic logic [15:0] lfsr_n(input int n);
      logic [15:0] v = 16'hACE1;
      for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
      return v;
   endfunction

   // Bus monitor / memory model for dut0; everything decided on the falling edge.
   logic [15:0] mem0 [logic [23:0]];
   logic [23:0] wr_addr_log [$];
   logic [15:0] wr_data_log [$];
   logic [23:0] rd_addr_log [$];
   int          rd_n0      = 0;
   int          force_rd0  = 0;
   int          cyc0       = 0;
   int          nonidle0   = 0;
   int          done_cnt0  = 0;
   int          bad_strb0  = 0;

   always @(negedge clk_114) begin
      cyc0++;
      if (done0) done_cnt0++;
      if (cpuState0 != 2'b01) nonidle0++;
      if ((cpuState0 != 2'b01) && (cpuL0 || cpuU0)) bad_strb0++;
      if ((cpuState0 == 2'b01) && !(cpuL0 && cpuU0)) bad_strb0++;
      clkena0 = ((cyc0 % 4) == 3);
      if (clkena0) begin
         if (cpuState0 == 2'b11) begin
            wr_addr_log.push_back(cpuAddr0);
            wr_data_log.push_back(cpuWR0);
            mem0[cpuAddr0] = cpuWR0;
         end else if (cpuState0 == 2'b10) begin
            rd_n0++;
            rd_addr_log.push_back(cpuAddr0);
            if (rd_n0 == force_rd0) cpuRD0 = 16'h0000;
            else if (mem0.exists(cpuAddr0)) cpuRD0 = mem0[cpuAddr0];
            else cpuRD0 = 16'hDEAD;
         end
      end
   end

   // dut1 monitor: log bus-cycle type at each strobe while a test runs.
   logic [15:0] mem1 [logic [23:0]];
   logic [1:0]  seq1 [$];
   always @(negedge clk_114) begin
      if (busy1 && !done1) begin
         seq1.push_back(cpuState1);
         if (cpuState1 == 2'b11) mem1[cpuAddr1] = cpuWR1;
         if (cpuState1 == 2'b10) cpuRD1 = mem1.exists(cpuAddr1) ? mem1[cpuAddr1] : 16'hDEAD;
      end
   end

   task automatic clear_logs();
      wr_addr_log.delete();
      wr_data_log.delete();
      rd_addr_log.delete();
      mem0.delete();
      rd_n0 = 0;
   endtask

   task automatic start_dut0(input logic [23:0] b, input logic [15:0] l);
      @(negedge clk_114);
      base0  = b;
      len0   = l;
      start0 = 1'b1;
      @(negedge clk_114);
      start0 = 1'b0;
   endtask

   task automatic wait_done0(input string tag, output int waited);
      waited = 0;
      while (!done0 && waited < 4000) begin
         @(negedge clk_114);
         waited++;
      end
      if (!done0) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   int w;
   int dc;
   logic [1:0] exp_seq [10] = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01,
                                2'b10, 2'b01, 2'b01, 2'b10};

   initial begin
      repeat (3) @(negedge clk_114);
      // reset values
      check("rst_state", {30'd0, cpuState0}, 32'd1);
      check("rst_strobe", {30'd0, cpuL0, cpuU0}, 32'd3);
      check("rst_addr", {8'd0, cpuAddr0}, 32'd0);
      check("rst_wr", {16'd0, cpuWR0}, 32'd0);
      check("rst_flags", {29'd0, busy0, done0, pass0}, 32'd0);
      check("rst_err", {16'd0, err_count0}, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_114);

      // 1: ideal memory, 4 words
      clear_logs();
      start_dut0(24'h000100, 16'd4);
      wait_done0("t1", w);
      check("t1_pass", {31'd0, pass0}, 32'd1);
      check("t1_errcnt", {16'd0, err_count0}, 32'd0);
      check("t1_nwr", wr_addr_log.size(), 32'd4);
      check("t1_nrd", rd_addr_log.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < wr_addr_log.size()) begin
            check($sformatf("t1_wa%0d", i), {8'd0, wr_addr_log[i]}, 32'h100 + i);
            check($sformatf("t1_wd%0d", i), {16'd0, wr_data_log[i]}, {16'd0, lfsr_tab[i]});
         end
         if (i < rd_addr_log.size())
            check($sformatf("t1_ra%0d", i), {8'd0, rd_addr_log[i]}, 32'h100 + i);
      end
      check("t1_lw", {31'd0, cpuLW0}, 32'd0);
      @(negedge clk_114);
      check("t1_idle_busy", {31'd0, busy0}, 32'd0);
      check("t1_done_once", {31'd0, done0}, 32'd0);
      check("t1_pass_hold", {31'd0, pass0}, 32'd1);

      // 2: forced zero on third read
      clear_logs();
      force_rd0 = 3;
      start_dut0(24'h000100, 16'd4);
      wait_done0("t2", w);
      force_rd0 = 0;
      check("t2_errcnt", {16'd0, err_count0}, 32'd1);
      check("t2_erraddr", {8'd0, err_addr0}, 32'h000102);
      check("t2_errdata", {16'd0, err_data0}, 32'h0000);
      check("t2_errexp", {16'd0, err_exp0}, 32'hB387);
      check("t2_pass", {31'd0, pass0}, 32'd0);

      // 3: zero length
      clear_logs();
      @(negedge clk_114);
      nonidle0 = 0;
      start_dut0(24'h000040, 16'd0);
      wait_done0("t3", w);
      check("t3_latency_ok", {31'd0, (w <= 1)}, 32'd1);
      check("t3_pass", {31'd0, pass0}, 32'd1);
      check("t3_errcnt", {16'd0, err_count0}, 32'd0);
      @(negedge clk_114);
      check("t3_nonidle", nonidle0, 32'd0);

      // 4: address wrap, plus a start while busy that must be ignored
      clear_logs();
      start_dut0(24'hFFFFFE, 16'd4);
      repeat (3) @(negedge clk_114);
      base0 = 24'h000000; len0 = 16'd1; start0 = 1'b1;
      @(negedge clk_114);
      start0 = 1'b0;
      wait_done0("t4", w);
      check("t4_pass", {31'd0, pass0}, 32'd1);
      check("t4_nwr", wr_addr_log.size(), 32'd4);
      if (wr_addr_log.size() == 4) begin
         check("t4_wa0", {8'd0, wr_addr_log[0]}, 32'hFFFFFE);
         check("t4_wa1", {8'd0, wr_addr_log[1]}, 32'hFFFFFF);
         check("t4_wa2", {8'd0, wr_addr_log[2]}, 32'h000000);
         check("t4_wa3", {8'd0, wr_addr_log[3]}, 32'h000001);
      end

      // 5: IDLE_GAP=2 on dut1
      seq1.delete();
      @(negedge clk_114);
      base1 = 24'h000300; len1 = 16'd2; start1 = 1'b1;
      @(negedge clk_114);
      start1 = 1'b0;
      w = 0;
      while (!done1 && w < 200) begin
         @(negedge clk_114);
         w++;
      end
      if (!done1) check("t5_timeout", 32'd0, 32'd1);
      check("t5_pass", {31'd0, pass1}, 32'd1);
      check("t5_nseq", seq1.size(), 32'd10);
      for (int i = 0; i < 10; i++)
         if (i < seq1.size()) check($sformatf("t5_seq%0d", i), {30'd0, seq1[i]}, {30'd0, exp_seq[i]});

      // 6: reset during read phase, then a clean full run
      clear_logs();
      start_dut0(24'h000200, 16'd16);
      w = 0;
      while (rd_n0 < 2 && w < 1000) begin
         @(negedge clk_114);
         w++;
      end
      check("t6_in_read", {31'd0, (rd_n0 >= 2)}, 32'd1);
      dc = done_cnt0;
      reset_n = 1'b0;
      #1;
      check("t6_rst_state", {30'd0, cpuState0}, 32'd1);
      check("t6_rst_strobe", {30'd0, cpuL0, cpuU0}, 32'd3);
      check("t6_rst_addr", {8'd0, cpuAddr0}, 32'd0);
      check("t6_rst_wr", {16'd0, cpuWR0}, 32'd0);
      check("t6_rst_flags", {29'd0, busy0, done0, pass0}, 32'd0);
      repeat (4) @(negedge clk_114);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_114);
      check("t6_no_done", done_cnt0, dc);
      clear_logs();
      start_dut0(24'h000200, 16'd16);
      wait_done0("t6", w);
      check("t6_pass", {31'd0, pass0}, 32'd1);
      check("t6_errcnt", {16'd0, err_count0}, 32'd0);
      check("t6_nwr", wr_addr_log.size(), 32'd16);
      if (wr_data_log.size() == 16)
         check("t6_wd15", {16'd0, wr_data_log[15]}, {16'd0, lfsr_n(15)});
      check("bus_strobes", bad_strb0, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1);
   end

endmodule
